// File: rtl/disp_pkg.sv
// Shared seven-segment display constants: blank pattern, active-low hex
// segment table ({g,f,e,d,c,b,a}) and the scan indices that bound a frame.
package disp_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Entry n is the active-low pattern for hex digit n.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   localparam logic [1:0] FRAME_LAST_SEL  = 2'b11;
   localparam logic [1:0] FRAME_FIRST_SEL = 2'b00;

endpackage

// File: rtl/seg_display_mux_if.sv
// Bus between the anode scanner / value source and seg_display_mux.
// master drives scan index, anodes and load data; slave drives the display.
interface seg_display_mux_if;

   logic [1:0]  seg_sel;
   logic [3:0]  an_in;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic        ld;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an_out;
   logic        pend;
   logic        upd_done;

   modport master (
      output seg_sel, an_in, din, dp_in, ld,
      input  seg, dp, an_out, pend, upd_done
   );

   modport slave (
      input  seg_sel, an_in, din, dp_in, ld,
      output seg, dp, an_out, pend, upd_done
   );

endinterface

// File: rtl/seg_display_mux_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_to_7seg
   import disp_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit multiplexed 7-segment driver with double-buffered, frame-aligned
// updates. Optional leading-zero blanking: define LEAD_ZERO_BLANK_EN.
module seg_display_mux
   import disp_pkg::*;
(
   input logic              clk,
   input logic              reset,
   seg_display_mux_if.slave bus
);

   logic [15:0] disp_q, disp_d, buf_q, buf_d;
   logic [3:0]  dpr_q, dpr_d, bdp_q, bdp_d;
   logic        pend_q, pend_d;
   logic        upd_q, upd_d;
   logic [1:0]  prev_sel_q;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic [3:0]  an_q;
   logic        commit;
   logic        sel_ok;
   logic [3:0]  nib;
   logic [3:0]  lz;
   logic [6:0]  hex_seg;

   always_comb begin
      commit = (prev_sel_q == FRAME_LAST_SEL) && (bus.seg_sel == FRAME_FIRST_SEL) && pend_q;
      disp_d = disp_q;
      dpr_d  = dpr_q;
      buf_d  = buf_q;
      bdp_d  = bdp_q;
      pend_d = pend_q;
      upd_d  = 1'b0;
      if (commit) begin
         disp_d = buf_q;
         dpr_d  = bdp_q;
         pend_d = 1'b0;
         upd_d  = 1'b1;
      end
      // A load in the commit cycle refills the buffer after the old contents moved out.
      if (bus.ld) begin
         buf_d  = bus.din;
         bdp_d  = bus.dp_in;
         pend_d = 1'b1;
      end
   end

   // Decode from the post-commit value so digit 0 of a new frame already shows it.
   always_comb begin
      nib    = '0;
      sel_ok = 1'b1;
      case (bus.seg_sel)
         2'd0:    nib = disp_d[3:0];
         2'd1:    nib = disp_d[7:4];
         2'd2:    nib = disp_d[11:8];
         2'd3:    nib = disp_d[15:12];
         default: sel_ok = 1'b0;
      endcase
   end

`ifdef LEAD_ZERO_BLANK_EN
   always_comb begin
      lz[3] = (disp_d[15:12] == 4'h0);
      lz[2] = lz[3] && (disp_d[11:8] == 4'h0);
      lz[1] = lz[2] && (disp_d[7:4] == 4'h0);
      lz[0] = 1'b0;
   end
`else
   assign lz = '0;
`endif

   hex_to_7seg u_dec (
      .nib_i (nib),
      .seg_o (hex_seg)
   );

   always_comb begin
      seg_d = (!sel_ok || lz[bus.seg_sel]) ? SEG_OFF : hex_seg;
      dp_d  = ~dpr_d[bus.seg_sel];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_q     <= '0;
         dpr_q      <= '0;
         buf_q      <= '0;
         bdp_q      <= '0;
         pend_q     <= 1'b0;
         upd_q      <= 1'b0;
         prev_sel_q <= 2'b00;
         seg_q      <= SEG_OFF;
         dp_q       <= 1'b1;
         an_q       <= '1;
      end else begin
         disp_q     <= disp_d;
         dpr_q      <= dpr_d;
         buf_q      <= buf_d;
         bdp_q      <= bdp_d;
         pend_q     <= pend_d;
         upd_q      <= upd_d;
         prev_sel_q <= bus.seg_sel;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= bus.an_in;
      end
   end

   assign bus.seg      = seg_q;
   assign bus.dp       = dp_q;
   assign bus.an_out   = an_q;
   assign bus.pend     = pend_q;
   assign bus.upd_done = upd_q;

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have no parameters; widths are fixed: 4 digits, 4-bit hex nibbles, 7 segments plus decimal point.
REQ-002 SHALL have port `clk`: input, 1 bit, single clock for all state.
REQ-003 SHALL have port `reset`: input, 1 bit, asynchronous, active-high.
REQ-004 SHALL have port `seg_sel`: input, 2 bits, index of the currently scanned digit from the anode scanner; 0 = rightmost digit.
REQ-005 SHALL have port `an_in`: input, 4 bits, active-low anode vector from the anode scanner, ordered {a3,a2,a1,a0}.
REQ-006 SHALL have port `din`: input, 16 bits, value to display; digit n = din[4n+3:4n].
REQ-007 SHALL have port `dp_in`: input, 4 bits, decimal-point enable per digit; 1 = lit.
REQ-008 SHALL have port `ld`: input, 1 bit, load strobe that captures `din` and `dp_in` into the pending buffer.
REQ-009 SHALL have port `seg`: output, 7 bits, registered segment vector {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port `dp`: output, 1 bit, registered decimal point, active-low.
REQ-011 SHALL have port `an_out`: output, 4 bits, registered copy of `an_in`, aligned with `seg`/`dp`.
REQ-012 SHALL have port `pend`: output, 1 bit, high while a loaded value awaits commit.
REQ-013 SHALL have port `upd_done`: output, 1 bit, one-cycle pulse on the cycle a commit occurs.

Function
REQ-014 SHALL, when `ld`=1 on a clock edge, write `din`/`dp_in` into the pending buffer and set `pend`; a later `ld` before commit overwrites the buffer.
REQ-015 SHALL detect a frame boundary as registered prev_sel==2'b11 together with `seg_sel`==2'b00.
REQ-016 SHALL, on a frame boundary with `pend`=1, copy the pending buffer to the display register, clear `pend`, and pulse `upd_done` high for one cycle.
REQ-017 SHALL, when `ld` and a commit coincide, commit the old buffer contents, capture the new `din`, and leave `pend`=1.
REQ-018 SHALL update `seg`, `dp` and `an_out` on every edge from the current `seg_sel`/`an_in` and the display register; latency is 1 cycle.
REQ-019 SHALL decode the selected nibble as standard hex 0-F: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
REQ-020 SHALL drive `dp` = ~dp_reg[seg_sel].
REQ-021 SHALL decode `seg_sel` values outside 0-3 as blank, although this cannot occur with a 2-bit index; the branch exists for lint completeness.
REQ-022 SHALL make the display register change only at frame boundaries, so that a frame never mixes old and new values.

Reset
REQ-023 SHALL, on asserted `reset`, immediately force: display register 16'h0000; dp register 4'b0000; pending buffer 0; `pend`=0; prev_sel=2'b00; `seg`=7'b1111111; `dp`=1; `an_out`=4'b1111; `upd_done`=0.
REQ-024 SHALL discard any pending load when reset is asserted mid-frame; no commit follows reset release until a new `ld` is received.
REQ-025 SHALL NOT treat the first `seg_sel`=00 after reset as a frame boundary.

Configuration
REQ-026 SHALL use macro LEAD_ZERO_BLANK_EN; when it is defined, leading-zero blanking applies:
- digit 3 is blanked if n3==0;
- digit 2 is blanked if n3==n2==0;
- digit 1 is blanked if n3..n1==0;
- digit 0 is never blanked;
- a blanked digit drives `seg`=1111111 but still honours `dp`.
REQ-027 SHALL, when LEAD_ZERO_BLANK_EN is undefined, show all four digits always, zeros included.

Structure
REQ-028 SHALL place the following in shared package disp_pkg, reused by the anode scanner and any future display blocks:
- SEG_OFF;
- the hex segment constant table;
- FRAME_LAST_SEL=2'b11 and FRAME_FIRST_SEL=2'b00.
REQ-029 SHALL isolate the combinational nibble-to-segment decode in sub-module hex_to_7seg; all registers stay in seg_display_mux.

Verification
REQ-030 SHALL cover load-then-frame: reset, then `ld` with din=16'h12AF, then scan 00..11,00 → `pend`=1 until the boundary; `upd_done` pulses once; digit0 `seg`=0001110 (F) one cycle after seg_sel=00.
REQ-031 SHALL cover double load: `ld` 16'h1111, then `ld` 16'h2222 before the boundary → commit shows 2222 only; exactly one `upd_done`.
REQ-032 SHALL cover coincident load: `ld` 16'h3333 on the boundary cycle while 16'h4444 is pending → display shows 4444, `pend` stays 1, next boundary shows 3333.
REQ-033 SHALL cover blanking with LEAD_ZERO_BLANK_EN defined and din=16'h0070 → digits 3 and 2 give `seg`=1111111, digit1 gives 1111000 (7), digit0 gives 1000000 (0); with the macro undefined, digits 3 and 2 show 1000000.
REQ-034 SHALL cover reset mid-operation: `ld` 16'hBEEF, then assert `reset` before the boundary → outputs go to reset values at once, `pend`=0, and no `upd_done` occurs over the next two frames.
REQ-035 SHALL cover alignment: for every cycle, `an_out` equals `an_in` delayed by 1 cycle and `seg` matches the digit selected in the same delayed cycle; dp_in=4'b0100 gives `dp`=0 only when `an_out`=1011.
